// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - shared constants, FSM states and parity helper for the SL transmitter
package sl_pkg;

   localparam int PIE_BIT = 0;
   localparam int BQ_LO   = 1;
   localparam int BQ_HI   = 6;

   localparam int BSY_BIT = 0;
   localparam int WDF_BIT = 1;
   localparam int CRJ_BIT = 2;

   localparam logic [15:0] CONFIG_RESET = 16'h0010;
   localparam logic [5:0]  BQ_MIN       = 6'd8;
   localparam logic [5:0]  BQ_MAX       = 6'd32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA_LOW,
      ST_DATA_HIGH,
      ST_PAR_LOW,
      ST_PAR_HIGH,
      ST_STOP_LOW,
      ST_STOP_HIGH
   } sl_state_t;

   // Bit that makes the number of ones over the low bq data bits plus itself odd.
   function automatic logic odd_parity(input logic [31:0] data, input logic [5:0] bq);
      logic acc;
      acc = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(bq)) acc ^= data[i];
      end
      return acc;
   endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// rtl/sl_bit_timer.sv - phase length down-counter for the SL bit low/high phases
module sl_bit_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] len,
   output logic       phase_end,
   output logic       near_end
);

   logic [5:0] cnt;

   // Loaded with len-1 when a phase starts, so phase_end marks its len-th cycle.
   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (load) cnt <= len - 6'd1;
      else           cnt <= cnt - 6'd1;
   end

   assign phase_end = (cnt == 6'd0);
   assign near_end  = (cnt == 6'd1);

endmodule

// File: rtl/sl_transmitter.sv
// rtl/sl_transmitter.sv - SL two-wire word transmitter with odd parity and stop bit
module sl_transmitter #(
   parameter int CONFIG_WIDTH    = 16,
   parameter int STATUS_WIDTH    = 16,
   parameter int BIT_LOW_CYCLES  = 8,
   parameter int BIT_HIGH_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [CONFIG_WIDTH-1:0] wr_config_w,
   input  logic                    wr_enable,
   output logic [CONFIG_WIDTH-1:0] r_config_w,
   output logic [STATUS_WIDTH-1:0] status_w,
   output logic                    tx_done,
   output logic                    serial_line_zeroes,
   output logic                    serial_line_ones
);
   import sl_pkg::*;

   sl_state_t               state, state_next;
   logic [CONFIG_WIDTH-1:0] config_reg;
   logic [31:0]             shreg, shreg_next;
   logic [5:0]              bq_snap, bit_cnt, bq_w;
   logic                    par_bit, accept, cfg_ok, done_next;
   logic                    zeroes_next, ones_next, is_low;
   logic                    bsy_q, wdf_q, crj_q;
   logic                    phase_end, near_end, tmr_load;

   assign bq_w   = wr_config_w[BQ_HI:BQ_LO];
   assign cfg_ok = wr_enable && (state == ST_IDLE) && !accept &&
                   (bq_w >= BQ_MIN) && (bq_w <= BQ_MAX) && !bq_w[0];

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         ST_IDLE:      if (tx_valid && tx_ready) begin
                          accept     = 1'b1;
                          state_next = ST_DATA_LOW;
                       end
         ST_DATA_LOW:  if (phase_end) state_next = ST_DATA_HIGH;
         ST_DATA_HIGH: if (phase_end) state_next = (bit_cnt == bq_snap - 6'd1) ? ST_PAR_LOW : ST_DATA_LOW;
         ST_PAR_LOW:   if (phase_end) state_next = ST_PAR_HIGH;
         ST_PAR_HIGH:  if (phase_end) state_next = ST_STOP_LOW;
         ST_STOP_LOW:  if (phase_end) state_next = ST_STOP_HIGH;
         ST_STOP_HIGH: if (phase_end) state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase

      shreg_next = shreg;
      if (accept) shreg_next = tx_data;
      else if (state == ST_DATA_HIGH && state_next == ST_DATA_LOW) shreg_next = shreg >> 1;

      // Line levels are computed for the state being entered so they change on the same edge.
      zeroes_next = 1'b1;
      ones_next   = 1'b1;
      case (state_next)
         ST_DATA_LOW: begin zeroes_next = shreg_next[0]; ones_next = ~shreg_next[0]; end
         ST_PAR_LOW:  begin zeroes_next = par_bit;       ones_next = ~par_bit;       end
         ST_STOP_LOW: begin zeroes_next = 1'b0;          ones_next = 1'b0;           end
         default:     ;
      endcase

      is_low    = (state_next == ST_DATA_LOW) || (state_next == ST_PAR_LOW) ||
                  (state_next == ST_STOP_LOW);
      tmr_load  = (state_next != state) && (state_next != ST_IDLE);
      done_next = (state == ST_STOP_HIGH) && near_end;
   end

   sl_bit_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (tmr_load),
      .len       (is_low ? 6'(BIT_LOW_CYCLES) : 6'(BIT_HIGH_CYCLES)),
      .phase_end (phase_end),
      .near_end  (near_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         config_reg         <= CONFIG_WIDTH'(CONFIG_RESET);
         shreg              <= '0;
         bq_snap            <= BQ_MIN;
         bit_cnt            <= '0;
         par_bit            <= 1'b0;
         tx_ready           <= 1'b1;
         tx_done            <= 1'b0;
         serial_line_zeroes <= 1'b1;
         serial_line_ones   <= 1'b1;
         bsy_q              <= 1'b0;
         wdf_q              <= 1'b0;
         crj_q              <= 1'b0;
      end else begin
         state              <= state_next;
         shreg              <= shreg_next;
         tx_ready           <= (state_next == ST_IDLE);
         tx_done            <= done_next;
         serial_line_zeroes <= zeroes_next;
         serial_line_ones   <= ones_next;
         bsy_q              <= (state_next != ST_IDLE);
         if (accept) begin
            bq_snap <= config_reg[BQ_HI:BQ_LO];
            par_bit <= odd_parity(tx_data, config_reg[BQ_HI:BQ_LO]) ^ config_reg[PIE_BIT];
            bit_cnt <= '0;
            wdf_q   <= 1'b0;
         end else begin
            if (state == ST_DATA_HIGH && state_next == ST_DATA_LOW) bit_cnt <= bit_cnt + 6'd1;
            if (done_next) wdf_q <= 1'b1;
         end
         if (wr_enable) begin
            crj_q <= !cfg_ok;
            if (cfg_ok) config_reg <= wr_config_w;
         end
      end
   end

   assign r_config_w = config_reg;

   always_comb begin
      status_w          = '0;
      status_w[BSY_BIT] = bsy_q;
      status_w[WDF_BIT] = wdf_q;
      status_w[CRJ_BIT] = crj_q;
   end

endmodule

// File: tb/tb_sl_transmitter.sv
// tb/tb_sl_transmitter.sv - scoreboard bench: line decoder monitor checks words against queued expectations
`timescale 1ns/1ps
module tb_sl_transmitter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] wr_config_w;
   logic        wr_enable;
   logic [15:0] r_config_w;
   logic [15:0] status_w;
   logic        tx_done;
   logic        sl_z, sl_o;

   always #31.25 clk = ~clk;

   sl_transmitter dut (
      .clk                (clk),
      .rst                (rst),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .wr_config_w        (wr_config_w),
      .wr_enable          (wr_enable),
      .r_config_w         (r_config_w),
      .status_w           (status_w),
      .tx_done            (tx_done),
      .serial_line_zeroes (sl_z),
      .serial_line_ones   (sl_o)
   );

   typedef struct {
      logic [31:0] data;
      int          bq;
      logic        par;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Line decoder / scoreboard monitor
   int          cyc = 0, low_len = 0, high_len = 0, nbits = 0, got_bits = 0, start_cyc = 0;
   logic [33:0] bits;
   logic        sym_z, sym_o, in_word = 1'b0, pending = 1'b0;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] got_data;
      cyc++;
      if (rst) begin
         low_len = 0; high_len = 0; nbits = 0; in_word = 1'b0; pending = 1'b0;
      end else begin
         if (!sl_z || !sl_o) begin
            if (low_len == 0) begin
               if (!in_word) begin
                  in_word = 1'b1; start_cyc = cyc; nbits = 0;
               end else begin
                  check("high_gap", 64'(high_len), 64'd8);
               end
               sym_z = sl_z; sym_o = sl_o;
            end
            low_len++;
            high_len = 0;
         end else begin
            if (low_len != 0) begin
               check("low_len", 64'(low_len), 64'd8);
               if (!sym_z && !sym_o) begin
                  pending = 1'b1; got_bits = nbits; in_word = 1'b0;
               end else if (nbits < 34) begin
                  bits[nbits] = sym_z;
                  nbits++;
               end
               low_len = 0;
            end
            high_len++;
         end
         if (tx_done === 1'b1) begin
            if (!pending || exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL tx_done: unexpected pulse at cycle %0d, required none", cyc);
            end else begin
               e = exp_q.pop_front();
               pending = 1'b0;
               got_data = '0;
               for (int i = 0; i < e.bq; i++) got_data[i] = bits[i];
               check("bit_count", 64'(got_bits), 64'(e.bq + 1));
               check("data", 64'(got_data), 64'(e.data));
               check("parity", 64'(bits[e.bq]), 64'(e.par));
               check("word_len", 64'(cyc - start_cyc + 1), 64'((e.bq + 2) * 16));
            end
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 4000 && tx_ready !== 1'b1; i++) @(negedge clk);
      if (tx_ready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL wait_ready: got timeout required tx_ready=1");
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input int bq, input logic par);
      exp_t e;
      e.data = d; e.bq = bq; e.par = par;
      exp_q.push_back(e);
   endtask

   task automatic send_word(input logic [31:0] d, input int bq, input logic par);
      push_exp(d, bq, par);
      tx_data  = d;
      tx_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      tx_valid = 1'b0;
      check("accept_busy", 64'(tx_ready), 64'd0);
      wait_ready();
   endtask

   task automatic cfg_write(input logic [15:0] v);
      wr_config_w = v;
      wr_enable   = 1'b1;
      @(negedge clk);
      wr_enable   = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tx_data = '0; tx_valid = 1'b0; wr_config_w = '0; wr_enable = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_config", 64'(r_config_w), 64'h0010);
      check("rst_status", 64'(status_w), 64'h0);
      check("rst_lines", 64'({sl_z, sl_o}), 64'h3);
      check("rst_ready", 64'(tx_ready), 64'd1);
      check("rst_done", 64'(tx_done), 64'd0);

      send_word(32'h07, 8, 1'b0);
      check("status_wdf", 64'(status_w), 64'h0002);
      send_word(32'hA5, 8, 1'b1);

      cfg_write(16'h000E);
      check("cfg_bq7_keep", 64'(r_config_w), 64'h0010);
      check("cfg_bq7_crj", 64'(status_w[2]), 64'd1);
      cfg_write(16'h0011);
      check("cfg_pie", 64'(r_config_w), 64'h0011);
      check("cfg_pie_crj", 64'(status_w[2]), 64'd0);
      send_word(32'h07, 8, 1'b1);
      cfg_write(16'h0040);
      check("cfg_bq32", 64'(r_config_w), 64'h0040);
      check("cfg_bq32_crj", 64'(status_w[2]), 64'd0);

      // Back-to-back with tx_valid held; config write during the first word
      push_exp(32'h1234_5678, 32, 1'b0);
      push_exp(32'hDEAD_BEEF, 32, 1'b1);
      tx_data  = 32'h1234_5678;
      tx_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      tx_data = 32'hDEAD_BEEF;
      check("b2b_busy", 64'(tx_ready), 64'd0);
      cfg_write(16'h0010);
      check("busy_cfg_keep", 64'(r_config_w), 64'h0040);
      check("busy_cfg_crj", 64'(status_w[2]), 64'd1);
      wait_ready();
      @(negedge clk);
      tx_valid = 1'b0;
      check("b2b_second_accept", 64'(tx_ready), 64'd0);
      check("b2b_bsy", 64'(status_w[0]), 64'd1);
      wait_ready();

      // wr_enable in the transfer cycle is rejected
      cfg_write(16'h0010);
      check("cfg_restore", 64'(r_config_w), 64'h0010);
      push_exp(32'hC3, 8, 1'b1);
      tx_data = 32'hC3; tx_valid = 1'b1; wr_config_w = 16'h0014; wr_enable = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0; wr_enable = 1'b0;
      check("xfer_cfg_keep", 64'(r_config_w), 64'h0010);
      check("xfer_cfg_status", 64'(status_w), 64'h0005);
      wait_ready();

      // Reset in the middle of a word
      cfg_write(16'h0041);
      check("cfg_0041", 64'(r_config_w), 64'h0041);
      tx_data = 32'h5A5A_5A5A; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_lines", 64'({sl_z, sl_o}), 64'h3);
      check("midrst_ready", 64'(tx_ready), 64'd1);
      check("midrst_status", 64'(status_w), 64'h0);
      check("midrst_config", 64'(r_config_w), 64'h0010);
      rst = 1'b0;
      @(negedge clk);

      send_word(32'h3C, 8, 1'b1);
      repeat (4) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
